// File: rtl/startup_gate_pkg.sv
// rtl/startup_gate_pkg.sv - shared types and constants for startup_gate
package startup_gate_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int SETTLE_MAX   = 15;
  localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/startup_gate_if.sv
// rtl/startup_gate_if.sv - input/output valid-ready streams of startup_gate
interface startup_gate_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/startup_gate_fifo.sv
// rtl/startup_gate_fifo.sv - beat buffer with wrap-bit pointers and occupancy
module startup_gate_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              wr_data,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/startup_gate.sv
// rtl/startup_gate.sv - buffers a stream and releases it once init_ready has settled
// Optional checks: define STARTUP_GATE_ASSERT_EN.
module startup_gate
  import startup_gate_pkg::*;
#(
  parameter int DW     = 8,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    init_ready,
  startup_gate_if.slave           bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    active
);
  localparam int LW         = $clog2(DEPTH) + 1;
  localparam int SETTLE_EFF = (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_EFF - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [SETTLE_CNT_W-1:0] cnt;
  logic [SETTLE_CNT_W-1:0] cnt_nxt;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;

  // Acceptance depends only on space, so beats are buffered in every state.
  assign bus.in_ready  = rstn && !full;
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = ((state == ST_RUN) && !empty) || (state == ST_HOLD);
  assign pop           = bus.out_valid && bus.out_ready;
  assign active        = (state == ST_RUN);

  startup_gate_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.in_data),
    .rd_data (bus.out_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_WAIT: begin
        if (init_ready) begin
          cnt_nxt   = '0;
          state_nxt = (SETTLE_EFF == 0) ? ST_RUN : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!init_ready) begin
          state_nxt = ST_WAIT;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == SETTLE_LAST) begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // A beat already on offer must complete before release stops.
        if (!init_ready) begin
          state_nxt = (bus.out_valid && !bus.out_ready) ? ST_HOLD : ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

`ifdef STARTUP_GATE_ASSERT_EN
  logic [1:0] cov_step;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cov_step <= '0;
    end else if (state != state_nxt) begin
      if (state == ST_WAIT && state_nxt == ST_SETTLE)
        cov_step <= 2'd1;
      else if (state == ST_SETTLE && state_nxt == ST_RUN && cov_step == 2'd1)
        cov_step <= 2'd2;
      else if (state == ST_RUN && state_nxt == ST_HOLD && cov_step == 2'd2)
        cov_step <= 2'd3;
      else
        cov_step <= 2'd0;
    end
  end

  a_stall_stable: assert property (@(posedge clk) disable iff (!rstn)
    bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_data));
  a_no_valid_idle: assert property (@(posedge clk) disable iff (!rstn)
    (state == ST_WAIT || state == ST_SETTLE) |-> !bus.out_valid);
  a_level_max: assert property (@(posedge clk) disable iff (!rstn)
    level <= LW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rstn)
    full |-> !push);
  a_reset_quiet: assert property (@(posedge clk) disable iff (!rstn)
    $rose(rstn) |-> !bus.out_valid);
  c_full_cycle: cover property (@(posedge clk) disable iff (!rstn)
    cov_step == 2'd3 && state == ST_HOLD && state_nxt == ST_WAIT);
`endif

endmodule

// File: tb/tb_startup_gate.sv
// tb/tb_startup_gate.sv - vector table, corner sequences and random run against a queue model
module tb_startup_gate;
  localparam int DW     = 8;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          init_ready = 1'b0;
  logic [LW-1:0] level;
  logic          active;

  startup_gate_if #(.DW(DW)) bus ();

  startup_gate #(
    .DW     (DW),
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .init_ready (init_ready),
    .bus        (bus),
    .level      (level),
    .active     (active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          ir, iv, o;
    logic [7:0]  d;
    bit          e_inr, e_ov, e_act;
    logic [7:0]  e_d;
    int          e_lvl;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(int ir, int iv, int d, int o,
                              int ei, int eo, int ed, int el, int ea);
    vec_t v;
    v.ir = (ir != 0); v.iv = (iv != 0); v.d = 8'(d); v.o = (o != 0);
    v.e_inr = (ei != 0); v.e_ov = (eo != 0); v.e_d = 8'(ed);
    v.e_lvl = el; v.e_act = (ea != 0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and let outputs settle.
  task automatic drive(input int rs, input int ir, input int iv, input int d, input int o);
    @(negedge clk);
    rstn          = (rs != 0);
    init_ready    = (ir != 0);
    bus.in_valid  = (iv != 0);
    bus.in_data   = 8'(d);
    bus.out_ready = (o != 0);
    #1;
  endtask

  logic [7:0] mq[$];
  int         hi_cnt;
  bit         hold;

  initial begin
    logic [7:0] prev;
    int rs, ir, iv, d, o;
    bit m_act, m_ov, m_inr;

    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    drive(0, 0, 0, 0, 0);
    chk("reset in_ready", 32'(bus.in_ready), 0);
    drive(0, 0, 0, 0, 0);
    chk("reset level", 32'(level), 0);
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset active", 32'(active), 0);

    //          ir iv d      o   inr ov data  lvl act
    vt.push_back(mk(0, 1, 'h11, 0, 1, 0, 0,    0, 0));
    vt.push_back(mk(0, 1, 'h22, 0, 1, 0, 0,    1, 0));
    vt.push_back(mk(0, 1, 'h33, 0, 1, 0, 0,    2, 0));
    vt.push_back(mk(0, 1, 'h44, 0, 1, 0, 0,    3, 0));
    vt.push_back(mk(0, 1, 'h55, 0, 0, 0, 0,    4, 0));
    vt.push_back(mk(1, 0, 0,    0, 0, 0, 0,    4, 0));
    vt.push_back(mk(1, 0, 0,    0, 0, 0, 0,    4, 0));
    vt.push_back(mk(1, 0, 0,    0, 0, 0, 0,    4, 0));
    vt.push_back(mk(1, 0, 0,    0, 0, 1, 'h11, 4, 1));
    vt.push_back(mk(1, 0, 0,    1, 0, 1, 'h11, 4, 1));
    vt.push_back(mk(1, 0, 0,    1, 1, 1, 'h22, 3, 1));
    vt.push_back(mk(1, 0, 0,    1, 1, 1, 'h33, 2, 1));
    vt.push_back(mk(1, 0, 0,    1, 1, 1, 'h44, 1, 1));
    vt.push_back(mk(1, 0, 0,    1, 1, 0, 0,    0, 1));
    vt.push_back(mk(0, 1, 'h66, 0, 1, 0, 0,    0, 1));
    vt.push_back(mk(1, 0, 0,    0, 1, 0, 0,    1, 0));
    vt.push_back(mk(0, 0, 0,    0, 1, 0, 0,    1, 0));
    vt.push_back(mk(0, 0, 0,    0, 1, 0, 0,    1, 0));
    vt.push_back(mk(1, 0, 0,    0, 1, 0, 0,    1, 0));
    vt.push_back(mk(1, 0, 0,    0, 1, 0, 0,    1, 0));
    vt.push_back(mk(1, 0, 0,    0, 1, 0, 0,    1, 0));
    vt.push_back(mk(1, 0, 0,    0, 1, 1, 'h66, 1, 1));
    vt.push_back(mk(0, 0, 0,    0, 1, 1, 'h66, 1, 1));
    vt.push_back(mk(1, 0, 0,    0, 1, 1, 'h66, 1, 0));
    vt.push_back(mk(1, 0, 0,    1, 1, 1, 'h66, 1, 0));
    vt.push_back(mk(0, 0, 0,    0, 1, 0, 0,    0, 0));

    foreach (vt[i]) begin
      drive(1, int'(vt[i].ir), int'(vt[i].iv), int'(vt[i].d), int'(vt[i].o));
      chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vt[i].e_inr));
      chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vt[i].e_ov));
      if (vt[i].e_ov) chk($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'(vt[i].e_d));
      chk($sformatf("vec%0d level", i), 32'(level), vt[i].e_lvl);
      chk($sformatf("vec%0d active", i), 32'(active), 32'(vt[i].e_act));
    end

    // Steady flow: one entry resident, push and pop every cycle.
    drive(1, 1, 1, 'h5A, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("flow pre active", 32'(active), 0);
    prev = 8'h5A;
    drive(1, 1, 1, 'hA5, 1);
    chk("flow active", 32'(active), 1);
    chk("flow first data", 32'(bus.out_data), 32'(prev));
    chk("flow first level", 32'(level), 1);
    prev = 8'hA5;
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 1, 'h30 + i, 1);
      chk($sformatf("flow%0d valid", i), 32'(bus.out_valid), 1);
      chk($sformatf("flow%0d data", i), 32'(bus.out_data), 32'(prev));
      chk($sformatf("flow%0d level", i), 32'(level), 1);
      prev = 8'(8'h30 + i);
    end
    drive(1, 1, 0, 0, 0);
    chk("flow last data", 32'(bus.out_data), 32'(prev));
    chk("flow last level", 32'(level), 1);

    // Reset with three beats buffered.
    drive(1, 1, 1, 'hC1, 0);
    drive(1, 1, 1, 'hC2, 0);
    chk("pre-rst level2", 32'(level), 2);
    drive(0, 1, 0, 0, 0);
    chk("rst in_ready", 32'(bus.in_ready), 0);
    chk("rst level before edge", 32'(level), 3);
    drive(1, 0, 0, 0, 0);
    chk("post-rst level", 32'(level), 0);
    chk("post-rst out_valid", 32'(bus.out_valid), 0);
    chk("post-rst active", 32'(active), 0);
    chk("post-rst in_ready", 32'(bus.in_ready), 1);

    // Random traffic against a queue model; release after SETTLE+1 high samples.
    mq.delete(); hi_cnt = 0; hold = 0;
    ir = 0;
    for (int c = 0; c < 600; c++) begin
      rs = ($urandom_range(0, 99) == 0) ? 0 : 1;
      if ($urandom_range(0, 7) == 0) ir = 1 - ir;
      iv = int'($urandom_range(0, 1));
      d  = int'($urandom_range(0, 255));
      o  = ($urandom_range(0, 9) < 6) ? 1 : 0;
      m_act = !hold && (hi_cnt >= SETTLE + 1);
      m_ov  = hold || (m_act && mq.size() > 0);
      m_inr = (rs != 0) && (mq.size() < DEPTH);
      drive(rs, ir, iv, d, o);
      chk($sformatf("rnd%0d in_ready", c), 32'(bus.in_ready), 32'(m_inr));
      chk($sformatf("rnd%0d out_valid", c), 32'(bus.out_valid), 32'(m_ov));
      if (m_ov) chk($sformatf("rnd%0d out_data", c), 32'(bus.out_data), 32'(mq[0]));
      chk($sformatf("rnd%0d level", c), 32'(level), mq.size());
      chk($sformatf("rnd%0d active", c), 32'(active), 32'(m_act));
      if (rs == 0) begin
        mq.delete(); hi_cnt = 0; hold = 0;
      end else begin
        if (m_ov && o != 0) void'(mq.pop_front());
        if (m_inr && iv != 0) mq.push_back(8'(d));
        if (hold) begin
          if (o != 0) hold = 0;
          hi_cnt = 0;
        end else if (ir != 0) begin
          if (hi_cnt <= SETTLE) hi_cnt++;
        end else begin
          if (m_act && m_ov && o == 0) hold = 1;
          hi_cnt = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/startup_gate.md
# startup_gate

Gates a valid/ready data stream on the system init-ready signal. Sits directly downstream of the reset/init stage: it consumes that stage's `ready` output as `init_ready`. Input beats are buffered in a small FIFO from the first cycle after reset. Beats are released downstream only after `init_ready` has been high for a programmable settle period, and release stops cleanly if `init_ready` drops.

## Interface
- `DW`, 8, data width in bits (≥1).
- `DEPTH`, 4, FIFO entries; power of 2, ≥2.
- `SETTLE`, 2, cycles `init_ready` must be high before release; 0..15.

Reset rstn, synchronous, active-low; clock clk.

- `clk` in 1: clock, rising edge.
- `rstn` in 1: synchronous active-low reset.
- `init_ready` in 1: system ready from the upstream init stage.
- `in_valid` in 1: upstream beat valid.
- `in_data` in DW: upstream beat data.
- `in_ready` out 1: beat accepted when high with `in_valid`.
- `out_valid` out 1: downstream beat valid.
- `out_data` out DW: downstream beat data; this is the FIFO head.
- `out_ready` in 1: downstream accepts.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `active` out 1: high in state RUN.

## Operation
- **Reset values:** state WAIT, read/write pointers 0, `level`=0, `out_valid`=0, `active`=0, settle count 0.
- **`in_ready`:** equals `rstn && !full`, in every state.
  - Push occurs when `in_valid && in_ready`.
  - There is no pass-through when full, even if a pop occurs in the same cycle.
- **Pop:** occurs when `out_valid && out_ready`.
- **Simultaneous push and pop:** `level` is unchanged.
- **Pointers:** carry one extra wrap bit.
  - Full when indices are equal and wrap bits differ.
  - Empty when pointers are fully equal.
- **`out_valid`:** `(state==RUN && !empty) || state==HOLD`.
- **State machine:**
  - WAIT:
    - `init_ready`=1 and SETTLE=0 → RUN.
    - `init_ready`=1 and SETTLE>0 → SETTLE, count cleared.
  - SETTLE:
    - `init_ready`=0 → WAIT.
    - Otherwise the count increments; at count==SETTLE-1 → RUN.
  - RUN:
    - `init_ready`=0 and (`out_valid && !out_ready`) → HOLD.
    - `init_ready`=0 otherwise → WAIT.
  - HOLD:
    - `out_ready`=1 → WAIT, after the pending beat is popped.
    - The `init_ready` value is ignored in HOLD.
- **Handshake rule:** once `out_valid` rises, `out_valid` and `out_data` stay stable until `out_ready`.
- **Input while not releasing:** beats keep arriving in WAIT and SETTLE and are buffered until full. Nothing is ever dropped.
- **Reset mid-operation:** all contents are discarded and the block returns to the reset values on the next edge.

## Timing
- Input-to-output latency is 1 cycle minimum: a beat pushed at edge N is presented from cycle N+1, if the state is RUN.
- Release delay: with `init_ready` rising at edge N, `active` rises at edge N+SETTLE+1. For SETTLE=0 this is edge N+1.
- Throughput is 1 beat/cycle in RUN when `out_ready` is held high.

## Configuration
- Macro: `STARTUP_GATE_ASSERT_EN`.
- **Defined:** concurrent assertions are compiled in, all `disable iff (!rstn)`:
  - `out_valid` and `out_data` stable while stalled;
  - no `out_valid` in WAIT/SETTLE;
  - `level`≤DEPTH;
  - no push when full;
  - `out_valid`=0 in the first cycle after reset;
  - cover of a WAIT→SETTLE→RUN→HOLD→WAIT sequence.
- **Undefined:** the assertions are absent and the RTL is otherwise identical.

## Structure
- Package `startup_gate_pkg` contains:
  - the state enum typedef (WAIT, SETTLE, RUN, HOLD);
  - the `SETTLE_MAX`=15 constant;
  - the settle counter width constant (4).
- Sub-module `startup_gate_fifo`:
  - contains storage, pointers, `level`, `full` and `empty`;
  - the top owns the FSM and the handshake gating.

## Test plan
- **Buffer before release:** reset, then `init_ready`=0, push 0x11, 0x22, 0x33, 0x44 (DEPTH=4) → `level`=4, `in_ready`=0, `out_valid`=0 throughout.
- **Settle delay:** `init_ready` rises at edge N (SETTLE=2) → `active`=1 and `out_valid`=1 with `out_data`=0x11 from edge N+3. Data then drains 0x11..0x44 in order with `out_ready`=1.
- **Glitch during settle:** `init_ready` high 1 cycle then low → state returns to WAIT and `out_valid` never rises. A later 3-cycle-high pulse releases data.
- **Drop with stalled output:** `init_ready` falls with `out_valid`=1, `out_ready`=0 → state HOLD and `out_data` is held. `out_ready`=1 pops exactly one beat; `out_valid`=0 next cycle and `level` decrements by 1.
- **Steady flow:** in RUN with one entry, push 0xA5 and pop the same cycle → `level` unchanged. Continuous push/pop for 20 cycles gives 1 beat/cycle with no loss.
- **Reset mid-stream:** `rstn`=0 for one edge with `level`=3 → `level`=0, `out_valid`=0, `active`=0 and `in_ready`=0 during reset.
